// File: rtl/push_imm_fetch_if.sv
// Bundle of the start, code-memory and result handshakes of push_imm_fetch.
// imm_oob exists only when PUSH_IMM_OOB_FLAG_EN is defined.
interface push_imm_fetch_if #(
   parameter int ADDR_W = 16
);
   logic              start_valid;
   logic              start_ready;
   logic [7:0]        start_opcode;
   logic [ADDR_W-1:0] start_pc;
   logic [ADDR_W-1:0] code_len;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid;
   logic [7:0]        mem_rdata;
   logic              imm_valid;
   logic              imm_ready;
   logic [255:0]      imm_data;
   logic [ADDR_W-1:0] imm_pc_nxt;
   logic [31:0]       imm_gas;
   logic              imm_err;
`ifdef PUSH_IMM_OOB_FLAG_EN
   logic              imm_oob;
`endif

   // master = the fetch unit, slave = decode/memory/consumer side
   modport master (
      input  start_valid, start_opcode, start_pc, code_len,
      input  mem_rvalid, mem_rdata, imm_ready,
      output start_ready, mem_req, mem_addr,
      output imm_valid, imm_data, imm_pc_nxt, imm_gas, imm_err
`ifdef PUSH_IMM_OOB_FLAG_EN
      , output imm_oob
`endif
   );

   modport slave (
      output start_valid, start_opcode, start_pc, code_len,
      output mem_rvalid, mem_rdata, imm_ready,
      input  start_ready, mem_req, mem_addr,
      input  imm_valid, imm_data, imm_pc_nxt, imm_gas, imm_err
`ifdef PUSH_IMM_OOB_FLAG_EN
      , input imm_oob
`endif
   );
endinterface

// File: rtl/push_imm_fetch.sv
// PUSH0..PUSH32 immediate fetch: one code byte per request, right-aligned big-endian result.
// Optional imm_oob pad flag via PUSH_IMM_OOB_FLAG_EN.
module push_imm_fetch #(
   parameter int ADDR_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   push_imm_fetch_if.master bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] nxt_q, nxt_d;
   logic [5:0]        nbytes_q, nbytes_d;
   logic [5:0]        idx_q, idx_d;
   logic [255:0]      acc_q, acc_d;
   logic [31:0]       gas_q, gas_d;
   logic              err_q, err_d;
   logic              oob_q, oob_d;

   // Byte address kept one bit wider so reads past the top of memory count as padding.
   logic [ADDR_W:0]   addr_ext;
   logic              in_bounds;
   logic              last_byte;
   logic              legal_op;
   logic              push0_op;
   logic [5:0]        start_nbytes;

   assign addr_ext  = {1'b0, pc_q} + (ADDR_W+1)'(1) + (ADDR_W+1)'(idx_q);
   assign in_bounds = addr_ext < {1'b0, len_q};
   assign last_byte = idx_q == (nbytes_q - 6'd1);

   assign legal_op     = (bus.start_opcode >= 8'h5F) && (bus.start_opcode <= 8'h7F);
   assign push0_op     = bus.start_opcode == 8'h5F;
   assign start_nbytes = (legal_op && !push0_op) ? ({1'b0, bus.start_opcode[4:0]} + 6'd1) : 6'd0;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      len_d    = len_q;
      nxt_d    = nxt_q;
      nbytes_d = nbytes_q;
      idx_d    = idx_q;
      acc_d    = acc_q;
      gas_d    = gas_q;
      err_d    = err_q;
      oob_d    = oob_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start_valid) begin
               pc_d     = bus.start_pc;
               len_d    = bus.code_len;
               nbytes_d = start_nbytes;
               nxt_d    = bus.start_pc + ADDR_W'(1) + ADDR_W'(start_nbytes);
               idx_d    = 6'd0;
               acc_d    = '0;
               oob_d    = 1'b0;
               err_d    = !legal_op;
               gas_d    = !legal_op ? 32'd0 : (push0_op ? 32'd2 : 32'd3);
               state_d  = (push0_op || !legal_op) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (in_bounds) begin
               state_d = S_WAIT;
            end else begin
               acc_d = {acc_q[247:0], 8'h00};
               oob_d = 1'b1;
               if (last_byte) state_d = S_DONE;
               else           idx_d   = idx_q + 6'd1;
            end
         end
         S_WAIT: begin
            if (bus.mem_rvalid) begin
               acc_d = {acc_q[247:0], bus.mem_rdata};
               if (last_byte) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 6'd1;
                  state_d = S_REQ;
               end
            end
         end
         default: begin
            if (bus.imm_ready) state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         len_q    <= '0;
         nxt_q    <= '0;
         nbytes_q <= '0;
         idx_q    <= '0;
         acc_q    <= '0;
         gas_q    <= '0;
         err_q    <= 1'b0;
         oob_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         len_q    <= len_d;
         nxt_q    <= nxt_d;
         nbytes_q <= nbytes_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         gas_q    <= gas_d;
         err_q    <= err_d;
         oob_q    <= oob_d;
      end
   end

   assign bus.start_ready = state_q == S_IDLE;
   assign bus.mem_req     = (state_q == S_REQ) && in_bounds;
   assign bus.mem_addr    = bus.mem_req ? addr_ext[ADDR_W-1:0] : '0;
   assign bus.imm_valid   = state_q == S_DONE;
   assign bus.imm_data    = acc_q;
   assign bus.imm_pc_nxt  = nxt_q;
   assign bus.imm_gas     = gas_q;
   assign bus.imm_err     = err_q;
`ifdef PUSH_IMM_OOB_FLAG_EN
   assign bus.imm_oob     = oob_q;
`endif
endmodule

// File: tb/tb_push_imm_fetch.sv
// Randomized bench for push_imm_fetch against a byte-level PUSH decode model.
// Define PUSH_IMM_OOB_FLAG_EN to also check imm_oob.
module tb_push_imm_fetch;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   push_imm_fetch_if #(.ADDR_W(16)) bus ();
   push_imm_fetch #(.ADDR_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0] code_mem [0:65535];
   int n_cmp = 0;
   int n_bad = 0;
   int lat   = 1;
   int txn_no = 0;
   int unsigned act_addr[$];
   int rsp_pend = 0;
   int rsp_cnt  = 0;
   int rsp_addr = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Code memory: answers each request lat cycles later; a response in flight survives rst.
   initial begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 8'h00;
      forever begin
         @(negedge clk);
         bus.mem_rvalid = 1'b0;
         if (rsp_pend != 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = code_mem[rsp_addr];
               rsp_pend       = 0;
            end
         end
         if (bus.mem_req === 1'b1) begin
            rsp_pend = 1;
            rsp_cnt  = lat;
            rsp_addr = int'(bus.mem_addr);
            act_addr.push_back(int'(bus.mem_addr));
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 256'(bus.start_ready), 256'(1));
      check({tag, "_valid"}, 256'(bus.imm_valid), 256'(0));
      check({tag, "_mreq"},  256'(bus.mem_req), 256'(0));
      check({tag, "_maddr"}, 256'(bus.mem_addr), 256'(0));
      check({tag, "_data"},  bus.imm_data, 256'(0));
      check({tag, "_pcnxt"}, 256'(bus.imm_pc_nxt), 256'(0));
      check({tag, "_gas"},   256'(bus.imm_gas), 256'(0));
      check({tag, "_err"},   256'(bus.imm_err), 256'(0));
`ifdef PUSH_IMM_OOB_FLAG_EN
      check({tag, "_oob"},   256'(bus.imm_oob), 256'(0));
`endif
   endtask

   task automatic run_txn(input logic [7:0] op, input int pc, input int len, input int l, input int hold);
      logic         legal;
      int           n;
      int           a;
      int           exp_lat;
      int           cyc;
      int           w;
      bit           pad;
      logic [255:0] exp_data;
      int unsigned  exp_addr[$];
      int           exp_pc;
      int           exp_gas;
      int           nchk;

      // Model: PUSHn reads the n bytes following pc, bytes at or past code_len are zero.
      legal    = (op >= 8'h5F) && (op <= 8'h7F);
      n        = (legal && op != 8'h5F) ? int'(op) - 'h5F : 0;
      exp_data = '0;
      exp_lat  = 1;
      pad      = 1'b0;
      for (int j = 0; j < n; j++) begin
         a = pc + 1 + j;
         if (a < len) begin
            exp_data = (exp_data << 8) | 256'(code_mem[a]);
            exp_addr.push_back(a);
            exp_lat += 1 + l;
         end else begin
            exp_data = exp_data << 8;
            pad      = 1'b1;
            exp_lat += 1;
         end
      end
      exp_pc  = (pc + 1 + n) % 65536;
      exp_gas = !legal ? 0 : (n == 0 ? 2 : 3);

      lat = l;
      act_addr.delete();
      @(negedge clk);
      bus.start_valid  = 1'b1;
      bus.start_opcode = op;
      bus.start_pc     = 16'(pc);
      bus.code_len     = 16'(len);
      w = 0;
      while (bus.start_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) begin
         check("start_ready_timeout", 256'(bus.start_ready), 256'(1));
         bus.start_valid = 1'b0;
         return;
      end
      cyc = 0;
      do begin
         @(negedge clk);
         bus.start_valid = 1'b0;
         cyc++;
      end while (bus.imm_valid !== 1'b1 && cyc < 400);
      check("latency", 256'(cyc), 256'(exp_lat));
      if (cyc >= 400) return;

      check("data",  bus.imm_data, exp_data);
      check("pcnxt", 256'(bus.imm_pc_nxt), 256'(exp_pc));
      check("gas",   256'(bus.imm_gas), 256'(exp_gas));
      check("err",   256'(bus.imm_err), 256'(!legal));
`ifdef PUSH_IMM_OOB_FLAG_EN
      check("oob",   256'(bus.imm_oob), 256'(pad));
`endif
      check("busy_ready", 256'(bus.start_ready), 256'(0));
      check("nreq", 256'(act_addr.size()), 256'(exp_addr.size()));
      nchk = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
      for (int k = 0; k < nchk; k++) check("addr", 256'(act_addr[k]), 256'(exp_addr[k]));

      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("hold_valid", 256'(bus.imm_valid), 256'(1));
         check("hold_data",  bus.imm_data, exp_data);
         check("hold_pcnxt", 256'(bus.imm_pc_nxt), 256'(exp_pc));
         check("hold_ready", 256'(bus.start_ready), 256'(0));
      end
      bus.imm_ready = 1'b1;
      @(negedge clk);
      bus.imm_ready = 1'b0;
      check("accept_valid", 256'(bus.imm_valid), 256'(0));
      check("accept_ready", 256'(bus.start_ready), 256'(1));
      txn_no++;
      $display("txn %0d op=%02h pc=%04h len=%04h L=%0d -> data=%0h pc_nxt=%04h gas=%0d err=%0b lat=%0d",
               txn_no, op, pc, len, l, bus.imm_data, bus.imm_pc_nxt, bus.imm_gas, bus.imm_err, cyc);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      for (int i = 0; i < 65536; i++) code_mem[i] = 8'($urandom);
      rst              = 1'b1;
      bus.start_valid  = 1'b0;
      bus.start_opcode = 8'h00;
      bus.start_pc     = 16'h0;
      bus.code_len     = 16'h0;
      bus.imm_ready    = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      run_txn(8'h5F, 'h10, 'h100, 1, 0);
      code_mem[0] = 8'h61; code_mem[1] = 8'hAB; code_mem[2] = 8'hCD;
      run_txn(8'h61, 0, 8, 1, 0);
      for (int k = 0; k < 32; k++) code_mem['h101 + k] = 8'(k + 1);
      run_txn(8'h7F, 'h100, 'h200, 1, 0);
      code_mem[6] = 8'hB6; code_mem[7] = 8'hB7;
      run_txn(8'h63, 5, 8, 2, 0);
      run_txn(8'h80, 'h30, 'h100, 1, 5);
      run_txn(8'h7F, 'hFFF0, 'hFFFF, 1, 0);

      // Reset while PUSH8 waits on memory; its late response must be dropped.
      for (int k = 0; k < 8; k++) code_mem['h21 + k] = 8'hE0 + 8'(k);
      code_mem['h41] = 8'h5A;
      lat = 2;
      @(negedge clk);
      bus.start_valid  = 1'b1;
      bus.start_opcode = 8'h67;
      bus.start_pc     = 16'h20;
      bus.code_len     = 16'h100;
      @(negedge clk);
      bus.start_valid = 1'b0;
      w = 0;
      while (bus.mem_req !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("rst_test_mreq", 256'(bus.mem_req), 256'(1));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("midrst");
      repeat (3) @(negedge clk);
      check_reset_outputs("midrst_after");
      run_txn(8'h60, 'h40, 'h100, 1, 0);

      for (int t = 0; t < 60; t++) begin
         logic [7:0] op;
         int pc;
         int len;
         if ($urandom_range(0, 9) == 0) op = 8'($urandom_range(0, 255));
         else                           op = 8'($urandom_range('h5F, 'h7F));
         if ($urandom_range(0, 7) == 0) pc = $urandom_range('hFFD0, 'hFFFF);
         else                           pc = $urandom_range(0, 1000);
         if ($urandom_range(0, 5) == 0) len = $urandom_range(0, 65535);
         else                           len = (pc + $urandom_range(0, 40)) % 65536;
         run_txn(op, pc, len, $urandom_range(1, 3), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
